timing_core: RTL and testbench

timing_core converts per-line tick tables into laser trigger pulses, synchronised to a resonant-mirror zero-crossing signal. Software fills double-buffered tick memories: two banks (MEM0/MEM1), each holding 5 frame memories. The core replays the active bank line by line and frame by frame. It requests a refill of the idle bank and switches banks after a programmed number of passes.

---
 rtl/timing_core.sv | 89 ++++++++
 tb/tb_timing_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/timing_core.sv
// timing_core: replays double-buffered per-line tick tables as laser trigger pulses,
// each line started by a mirror zero-crossing edge and delayed a quarter mirror cycle.
module timing_core #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 17,
  parameter int N_FRAMES_MAX = 5
) (
  input  logic              clk_r,
  input  logic              nrst_r,
  input  logic              zc_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic [2:0]        memory_selector_i,
  input  logic              mem_updated_i,
  input  logic [9:0]        points_per_line_i,
  input  logic [7:0]        lines_per_frame_i,
  input  logic [2:0]        number_of_frames_i,
  input  logic [7:0]        mem_cycles_i,
  input  logic [4:0]        pulse_length_i,
  input  logic [15:0]       quarter_mirror_cycle_delay_i,
  output logic              update_mem_o,
  output logic              laser_trigger_o,
  output logic              line_completed_o
);
  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;
  state_t state, state_n;
  // flat store addressed {bank, frame, point}; frame slots above the last are never written
  logic [DATA_W-1:0] mem [1 << (ADDR_W + 4)];
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] raddr;
  logic [2:0]        zc_s;
  logic [15:0]       dcnt, tcnt;
  logic [9:0]        pidx;
  logic [4:0]        pcnt;
  logic [7:0]        line, pass;
  logic [2:0]        frame;
  logic              bank, zc_edge, fire, run_end, line_wrap, frame_wrap, pass_wrap;
  always_comb begin
    zc_edge    = zc_s[1] ^ zc_s[2];
    fire       = state == RUN && points_per_line_i != '0 && {1'b0, tcnt} + 17'd1 >= {1'b0, rdata[15:0]};
    run_end    = points_per_line_i == '0 || (fire && pidx == points_per_line_i - 10'd1);
    // on a firing clock the next point is fetched so it is ready without a gap
    raddr      = state == RUN ? ADDR_W'(pidx) + ADDR_W'(fire) : '0;
    line_wrap  = line + 8'd1 >= (lines_per_frame_i == '0 ? 8'd1 : lines_per_frame_i);
    frame_wrap = frame + 3'd1 >= (number_of_frames_i == '0 ? 3'd1 : number_of_frames_i);
    pass_wrap  = pass + 8'd1 >= (mem_cycles_i == '0 ? 8'd1 : mem_cycles_i);
  end
  always_ff @(posedge clk_r or negedge nrst_r)
    if (!nrst_r) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (zc_edge ? DELAY : IDLE) :
              state == DELAY ? (dcnt <= 16'd1 ? RUN : DELAY) :
              state == RUN   ? (run_end ? DONE : RUN) : IDLE;
  always_comb begin
    update_mem_o     = ~bank;
    laser_trigger_o  = pcnt != '0;
    line_completed_o = state == DONE;
  end
  always_ff @(posedge clk_r or negedge nrst_r)
    if (!nrst_r) begin
      zc_s  <= '0;
      dcnt  <= '0;
      tcnt  <= '0;
      pidx  <= '0;
      pcnt  <= '0;
      line  <= '0;
      frame <= '0;
      pass  <= '0;
      bank  <= 1'b0;
    end else begin
      zc_s <= {zc_s[1:0], zc_i};
      dcnt <= state == IDLE ? quarter_mirror_cycle_delay_i : dcnt - 16'(dcnt != '0);
      tcnt <= state != RUN || fire ? '0 : tcnt + 16'd1;
      pidx <= state != RUN ? '0 : pidx + 10'(fire);
      pcnt <= fire && rdata[DATA_W-1] ? pulse_length_i : pcnt - 5'(pcnt != '0);
      if (state == DONE) begin
        line <= line_wrap ? '0 : line + 8'd1;
        if (line_wrap) frame <= frame_wrap ? '0 : frame + 3'd1;
        if (line_wrap && frame_wrap) pass <= pass_wrap ? '0 : pass + 8'd1;
        if (line_wrap && frame_wrap && pass_wrap && mem_updated_i) bank <= ~bank;
      end
    end
  always_ff @(posedge clk_r) begin
    if (we_i && memory_selector_i < 3'(N_FRAMES_MAX)) mem[{~bank, memory_selector_i, waddr_i}] <= wdata_i;
    rdata <= mem[{bank, frame, raddr}];
  end
endmodule

// File: tb/tb_timing_core.sv
// tb_timing_core: directed lines with hand-computed timing; a negedge monitor scores each
// completed line (rises, high cycles, first-rise and done latency, pulse tail, idle bank).
module tb_timing_core;
  logic        clk_r = 0, nrst_r = 0, zc_i = 0, we_i = 0, mem_updated_i = 1;
  logic [10:0] waddr_i = '0;
  logic [16:0] wdata_i = '0;
  logic [2:0]  memory_selector_i = '0, number_of_frames_i = 3'd1;
  logic [9:0]  points_per_line_i = '0;
  logic [7:0]  lines_per_frame_i = 8'd1, mem_cycles_i = 8'd1;
  logic [4:0]  pulse_length_i = 5'd3;
  logic [15:0] quarter_mirror_cycle_delay_i = '0;
  logic        update_mem_o, laser_trigger_o, line_completed_o;
  typedef struct {int t_zc; int first; int done; int rises; int hi; int tail; int upd;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, lines_done = 0, cyc = 0;
  timing_core dut (
    .clk_r(clk_r), .nrst_r(nrst_r), .zc_i(zc_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .we_i(we_i), .memory_selector_i(memory_selector_i), .mem_updated_i(mem_updated_i),
    .points_per_line_i(points_per_line_i), .lines_per_frame_i(lines_per_frame_i),
    .number_of_frames_i(number_of_frames_i), .mem_cycles_i(mem_cycles_i),
    .pulse_length_i(pulse_length_i), .quarter_mirror_cycle_delay_i(quarter_mirror_cycle_delay_i),
    .update_mem_o(update_mem_o), .laser_trigger_o(laser_trigger_o), .line_completed_o(line_completed_o)
  );
  always #5 clk_r = ~clk_r;
  always @(posedge clk_r) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask
  task automatic fill(input logic [2:0] sel, input int n, input int dt, input logic act);
    for (int i = 0; i < n; i++) begin
      we_i = 1;
      memory_selector_i = sel;
      waddr_i = 11'(i);
      wdata_i = {act, 16'(dt)};
      tick(1);
    end
    we_i = 0;
  endtask
  // starts one line and waits for the monitor to finish scoring it
  task automatic play(input int ppl, input int d, input int plen, input int first, input int done,
                      input int rises, input int hi, input int tail, input int upd, input bit noise);
    exp_t e;
    int tgt;
    points_per_line_i = 10'(ppl);
    quarter_mirror_cycle_delay_i = 16'(d);
    pulse_length_i = 5'(plen);
    zc_i = ~zc_i;
    e.t_zc = cyc; e.first = first; e.done = done; e.rises = rises; e.hi = hi; e.tail = tail; e.upd = upd;
    q.push_back(e);
    tgt = lines_done + 1;
    if (noise) begin
      tick(5);
      zc_i = ~zc_i;
      tick(495);
      zc_i = ~zc_i;
    end
    for (int i = 0; i < 5000 && lines_done < tgt; i++) tick(1);
    if (lines_done < tgt) begin
      errors++;
      checks++;
      $display("FAIL line_timeout: line %0d not completed, got %0d lines, expected %0d", tgt, lines_done, tgt);
      finish_sim();
    end
  endtask
  initial begin
    int rises = 0, hi = 0, first = -1, tail_cnt = 0;
    bit pend = 0, pend1 = 0, prev_l = 0;
    exp_t cur;
    forever @(negedge clk_r) begin
      if (!nrst_r) begin
        rises = 0; hi = 0; first = -1; pend = 0; pend1 = 0; prev_l = 0;
      end else begin
        if (pend) begin
          if (pend1) begin
            chk("update_mem_after_line", int'(update_mem_o), cur.upd);
            pend1 = 0;
          end
          if (laser_trigger_o) tail_cnt++;
          else begin
            chk("pulse_tail", tail_cnt, cur.tail);
            pend = 0;
            lines_done++;
          end
        end else begin
          if (laser_trigger_o) hi++;
          if (laser_trigger_o && !prev_l) begin
            rises++;
            if (first < 0) first = cyc;
          end
        end
        prev_l = laser_trigger_o;
        if (line_completed_o) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line_completed at cycle %0d: got 1, expected 0", cyc);
          end else begin
            cur = q.pop_front();
            chk("rises", rises, cur.rises);
            chk("high_cycles", hi, cur.hi);
            chk("first_rise_latency", first < 0 ? -1 : first - cur.t_zc, cur.first);
            chk("done_latency", cyc - cur.t_zc, cur.done);
            pend = 1; pend1 = 1; tail_cnt = 0;
          end
          rises = 0; hi = 0; first = -1;
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk_r);
    #1;
    chk("reset_update_mem", int'(update_mem_o), 1);
    chk("reset_laser", int'(laser_trigger_o), 0);
    chk("reset_line_completed", int'(line_completed_o), 0);
    nrst_r = 1;
    tick(2);
    for (int f = 0; f < 5; f++) fill(3'(f), 360, 5, 1'b0);
    // empty line just to swap banks so bank 0 becomes writable
    play(0, 2, 3, -1, 6, 0, 0, 0, 0, 0);
    fill(3'd0, 360, 5, 1'b1);
    fill(3'd1, 20, 2, 1'b1);
    play(360, 10, 3, -1, 1813, 0, 0, 0, 1, 0);
    mem_updated_i = 0;
    number_of_frames_i = 3'd2;
    play(360, 10, 3, 18, 1813, 360, 1078, 2, 1, 1);
    play(20, 0, 5, 6, 44, 1, 39, 4, 1, 0);
    number_of_frames_i = 3'd1;
    play(10, 3, 0, -1, 56, 0, 0, 0, 1, 0);
    lines_per_frame_i = 8'd2;
    number_of_frames_i = 3'd2;
    mem_updated_i = 1;
    play(20, 0, 3, 9, 104, 20, 58, 2, 1, 0);
    play(20, 0, 3, 9, 104, 20, 58, 2, 1, 0);
    play(20, 0, 3, 6, 44, 1, 39, 2, 1, 0);
    play(20, 0, 3, 6, 44, 1, 39, 2, 0, 0);
    mem_updated_i = 0;
    for (int i = 0; i < 4; i++) play(4, 0, 3, -1, 24, 0, 0, 0, 0, 0);
    zc_i = ~zc_i;
    tick(20);
    nrst_r = 0;
    #1;
    chk("midrun_reset_update_mem", int'(update_mem_o), 1);
    chk("midrun_reset_laser", int'(laser_trigger_o), 0);
    chk("midrun_reset_line_completed", int'(line_completed_o), 0);
    tick(2);
    nrst_r = 1;
    tick(40);
    chk("pending_lines", q.size(), 0);
    finish_sim();
  end
endmodule
